// File: rtl/fixed_softplus_lane_sequencer_if.sv
// Lane-vector valid/ready channel used for every bus of the softplus lane
// sequencer: the upstream beat, the downstream beat and both single-lane
// evaluator links.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The master holds data and valid stable until that edge. Valid
// never depends combinationally on ready.
interface fixed_softplus_lane_sequencer_if #(
    parameter int DW    = 16,
    parameter int LANES = 1
);
    logic [LANES-1:0][DW-1:0] data;
    logic                     valid;
    logic                     ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fixed_softplus_lane_sequencer.sv
// fixed_softplus_lane_sequencer
//
// Time-multiplexes one shared single-lane softplus evaluator across all N
// lanes of an activation beat. A beat is captured in IDLE, its lanes are
// issued one per handshake in BUSY together with a segment select, and the
// in-order results are collected into an output buffer. The finished beat is
// presented in DONE until it is accepted downstream.
//
// Optional feature: define SOFTPLUS_LANE_SEQ_PERF_EN to add the
// perf_busy_cycles / perf_beats counters and their output ports.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = BUSY, 2 = DONE).
module fixed_softplus_lane_sequencer #(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    fixed_softplus_lane_sequencer_if.slave        data_in_0,
    fixed_softplus_lane_sequencer_if.master       data_out_0,
    fixed_softplus_lane_sequencer_if.master       eval_in,
    output logic [2:0]                            eval_seg,
    fixed_softplus_lane_sequencer_if.slave        eval_out,
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
    output logic [31:0]                           perf_busy_cycles,
    output logic [31:0]                           perf_beats,
`endif
    output logic [1:0]                            dbg_state
);

    localparam int W  = DATA_IN_0_PRECISION_0;
    localparam int F  = DATA_IN_0_PRECISION_1;
    localparam int DW = DATA_OUT_0_PRECISION_0;
    localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Segment boundaries +-2.0 and +-4.0 in the input fixed-point format.
    localparam int SEG_C2 = 2 << F;
    localparam int SEG_C4 = 4 << F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [N-1:0][W-1:0]      in_buf_q, in_buf_d;
    logic [N-1:0][DW-1:0]     out_buf_q, out_buf_d;
    logic [CW-1:0]            issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]            collect_cnt_q, collect_cnt_d;
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
    logic [31:0]              perf_busy_q, perf_busy_d;
    logic [31:0]              perf_beats_q, perf_beats_d;
`endif

    logic                     issue_pending;
    logic                     collect_pending;
    logic                     issue_fire;
    logic                     collect_fire;
    logic [W-1:0]             eval_lane;
    logic signed [W-1:0]      eval_lane_s;
    logic [2:0]               seg_raw;

    // Handshake decodes; all are functions of registered state only.
    assign issue_pending   = (issue_cnt_q < N_CNT);
    assign collect_pending = (collect_cnt_q < N_CNT);

    assign eval_in.valid    = (state_q == S_BUSY) && issue_pending;
    assign eval_out.ready   = (state_q == S_BUSY) && collect_pending;
    assign issue_fire       = eval_in.valid && eval_in.ready;
    assign collect_fire     = eval_out.ready && eval_out.valid;

    // Input ready is a pure state decode, held low while reset is asserted
    // so no output is ever 1 during reset.
    assign data_in_0.ready  = rst && (state_q == S_IDLE);

    assign data_out_0.valid = (state_q == S_DONE);
    assign data_out_0.data  = out_buf_q;

    assign dbg_state        = state_q;

`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
    assign perf_busy_cycles = perf_busy_q;
    assign perf_beats       = perf_beats_q;
`endif

    // Select the lane addressed by the issue counter; it only moves on an
    // issue handshake, so the operand is stable across evaluator stalls.
    always_comb begin
        eval_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (issue_cnt_q == CW'(i)) begin
                eval_lane = in_buf_q[i];
            end
        end
    end

    assign eval_in.data[0] = eval_lane;

    // Segment select: signed range compare of the issued operand.
    always_comb begin
        eval_lane_s = $signed(eval_lane);
        if (int'(eval_lane_s) < -SEG_C4) begin
            seg_raw = 3'd0;
        end else if (int'(eval_lane_s) < -SEG_C2) begin
            seg_raw = 3'd1;
        end else if (int'(eval_lane_s) < 0) begin
            seg_raw = 3'd2;
        end else if (int'(eval_lane_s) < SEG_C2) begin
            seg_raw = 3'd3;
        end else if (int'(eval_lane_s) <= SEG_C4) begin
            seg_raw = 3'd4;
        end else begin
            seg_raw = 3'd5;
        end
    end

    // A zero operand maps to segment 3, so the select is forced to 0 while
    // reset is asserted.
    assign eval_seg = rst ? seg_raw : 3'd0;

    // Next-state logic: capture in IDLE, concurrent issue/collect in BUSY,
    // hold the finished beat in DONE.
    always_comb begin
        state_d       = state_q;
        in_buf_d      = in_buf_q;
        out_buf_d     = out_buf_q;
        issue_cnt_d   = issue_cnt_q;
        collect_cnt_d = collect_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (data_in_0.valid) begin
                    in_buf_d      = data_in_0.data;
                    issue_cnt_d   = '0;
                    collect_cnt_d = '0;
                    state_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                end
                if (collect_fire) begin
                    for (int i = 0; i < N; i++) begin
                        if (collect_cnt_q == CW'(i)) begin
                            out_buf_d[i] = eval_out.data[0];
                        end
                    end
                    collect_cnt_d = collect_cnt_q + CW'(1);
                    if (collect_cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (data_out_0.ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
    // Free-running performance counters, wrapping modulo 2^32.
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_beats_d = perf_beats_q;
        if (state_q == S_BUSY) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if ((state_q == S_DONE) && data_out_0.ready) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end
    end
`endif

    // State register; reset aborts any beat in flight and clears all buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            in_buf_q      <= '0;
            out_buf_q     <= '0;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
            perf_busy_q   <= '0;
            perf_beats_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            in_buf_q      <= in_buf_d;
            out_buf_q     <= out_buf_d;
            issue_cnt_q   <= issue_cnt_d;
            collect_cnt_q <= collect_cnt_d;
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
            perf_busy_q   <= perf_busy_d;
            perf_beats_q  <= perf_beats_d;
`endif
        end
    end

endmodule

// File: tb/tb_fixed_softplus_lane_sequencer.sv
// Testbench for fixed_softplus_lane_sequencer: an 8-lane instance with a
// behavioural evaluator (configurable latency and input stalls) plus a
// 1-lane instance driven cycle by cycle. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fixed_softplus_lane_sequencer;

    localparam int W  = 16;
    localparam int DW = 32;
    localparam int F  = 12;
    localparam int N  = 8;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-lane instance
    fixed_softplus_lane_sequencer_if #(.DW(W),  .LANES(N)) din_if();
    fixed_softplus_lane_sequencer_if #(.DW(DW), .LANES(N)) dout_if();
    fixed_softplus_lane_sequencer_if #(.DW(W),  .LANES(1)) ein_if();
    fixed_softplus_lane_sequencer_if #(.DW(DW), .LANES(1)) eout_if();
    logic [2:0] seg_m;
    logic [1:0] dbg_m;

    // 1-lane instance
    fixed_softplus_lane_sequencer_if #(.DW(W),  .LANES(1)) din1_if();
    fixed_softplus_lane_sequencer_if #(.DW(DW), .LANES(1)) dout1_if();
    fixed_softplus_lane_sequencer_if #(.DW(W),  .LANES(1)) ein1_if();
    fixed_softplus_lane_sequencer_if #(.DW(DW), .LANES(1)) eout1_if();
    logic [2:0] seg_1;
    logic [1:0] dbg_1;

`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
    logic [31:0] perf_busy_m, perf_beats_m, perf_busy_1, perf_beats_1;
`endif

    fixed_softplus_lane_sequencer #(
        .DATA_IN_0_PRECISION_0       (W),
        .DATA_IN_0_PRECISION_1       (F),
        .DATA_IN_0_PARALLELISM_DIM_0 (4),
        .DATA_IN_0_PARALLELISM_DIM_1 (2),
        .DATA_OUT_0_PRECISION_0      (DW)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din_if),
        .data_out_0       (dout_if),
        .eval_in          (ein_if),
        .eval_seg         (seg_m),
        .eval_out         (eout_if),
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
        .perf_busy_cycles (perf_busy_m),
        .perf_beats       (perf_beats_m),
`endif
        .dbg_state        (dbg_m)
    );

    fixed_softplus_lane_sequencer #(
        .DATA_IN_0_PRECISION_0       (W),
        .DATA_IN_0_PRECISION_1       (F),
        .DATA_IN_0_PARALLELISM_DIM_0 (1),
        .DATA_IN_0_PARALLELISM_DIM_1 (1),
        .DATA_OUT_0_PRECISION_0      (DW)
    ) u_dut_one (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din1_if),
        .data_out_0       (dout1_if),
        .eval_in          (ein1_if),
        .eval_seg         (seg_1),
        .eval_out         (eout1_if),
`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
        .perf_busy_cycles (perf_busy_1),
        .perf_beats       (perf_beats_1),
`endif
        .dbg_state        (dbg_1)
    );

    // Scoreboard counters and checker
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Evaluator model for the 8-lane instance: returns {operand, 100+k} for
    // the k-th lane issued in the current beat after lat_min..lat_max cycles.
    typedef struct {
        logic [DW-1:0] val;
        int            due;
    } pend_t;

    pend_t      pend_q[$];
    logic [2:0] seg_q[$];
    int         lat_min = 1;
    int         lat_max = 1;
    bit         stall_en = 1'b0;
    int         ev_idx = 0;
    int         ev_out_cnt = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [W-1:0] held_in;
    logic [2:0]   held_seg;
    logic [W-1:0] lane_v [N];

    initial begin
        ein_if.ready   = 1'b0;
        eout_if.valid  = 1'b0;
        eout_if.data   = '0;
        forever begin
            pend_t p;
            @(negedge clk);
            cyc++;
            if (!rst) begin
                pend_q.delete();
                stalled       = 1'b0;
                ein_if.ready  = 1'b0;
                eout_if.valid = 1'b0;
                eout_if.data  = '0;
                continue;
            end
            if (stalled) begin
                check("eval_in_hold", 64'(ein_if.data[0]), 64'(held_in));
                check("eval_seg_hold", 64'(seg_m), 64'(held_seg));
            end
            stalled = 1'b0;
            ein_if.ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ein_if.valid) begin
                if (ein_if.ready) begin
                    seg_q.push_back(seg_m);
                    p.val = {ein_if.data[0], 16'(100 + ev_idx)};
                    p.due = cyc + int'($urandom_range(lat_min, lat_max));
                    pend_q.push_back(p);
                    ev_idx++;
                end else begin
                    stalled  = 1'b1;
                    held_in  = ein_if.data[0];
                    held_seg = seg_m;
                end
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                eout_if.valid   = 1'b1;
                eout_if.data[0] = pend_q[0].val;
                if (eout_if.ready) begin
                    void'(pend_q.pop_front());
                    ev_out_cnt++;
                end
            end else begin
                eout_if.valid = 1'b0;
                eout_if.data  = '0;
            end
        end
    end

    // Driver: present lane_v as one beat; called on a falling edge.
    task automatic send_beat();
        int w;
        for (int k = 0; k < N; k++) din_if.data[k] = lane_v[k];
        ev_idx     = 0;
        ev_out_cnt = 0;
        seg_q.delete();
        din_if.valid = 1'b1;
        w = 0;
        while (!din_if.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!din_if.ready) begin
            check("in_accept_timeout", 64'd0, 64'd1);
            din_if.valid = 1'b0;
            return;
        end
        @(negedge clk);
        din_if.valid = 1'b0;
    endtask

    // Wait for the result beat, optionally check latency and hold it stalled
    // for 'hold' cycles, then accept it.
    task automatic expect_beat(input int exp_t, input int hold);
        int t;
        logic [DW-1:0] exp_l;
        t = 1;
        while (!dout_if.valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!dout_if.valid) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_t > 0) check("out_latency", 64'(t), 64'(exp_t));
        for (int h = 0; h < hold; h++) begin
            exp_l = {lane_v[h % N], 16'(100 + (h % N))};
            check("done_valid_held", 64'(dout_if.valid), 64'd1);
            check("done_in_ready_low", 64'(din_if.ready), 64'd0);
            check("done_lane_held", 64'(dout_if.data[h % N]), 64'(exp_l));
            @(negedge clk);
        end
        for (int k = 0; k < N; k++) begin
            exp_l = {lane_v[k], 16'(100 + k)};
            check("out_lane", 64'(dout_if.data[k]), 64'(exp_l));
        end
        dout_if.ready = 1'b1;
        @(negedge clk);
        dout_if.ready = 1'b0;
        check("post_out_valid", 64'(dout_if.valid), 64'd0);
        check("post_in_ready", 64'(din_if.ready), 64'd1);
    endtask

    logic [W-1:0] seg_lanes [N] = '{16'hC000, 16'hE000, 16'hFFFF, 16'h0000,
                                    16'h2000, 16'h4000, 16'h4001, 16'hBFFF};
    logic [2:0]   seg_exp   [N] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    // Directed sequence
    initial begin
        int w;
        rst = 1'b0;
        din_if.valid = 1'b0;
        din_if.data  = '0;
        dout_if.ready = 1'b0;
        din1_if.valid = 1'b0;
        din1_if.data  = '0;
        dout1_if.ready = 1'b0;
        ein1_if.ready  = 1'b0;
        eout1_if.valid = 1'b0;
        eout1_if.data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", 64'(din_if.ready), 64'd0);
        check("rst_out_valid", 64'(dout_if.valid), 64'd0);
        check("rst_out_data", 64'(|dout_if.data), 64'd0);
        check("rst_eval_in_valid", 64'(ein_if.valid), 64'd0);
        check("rst_eval_in", 64'(ein_if.data[0]), 64'd0);
        check("rst_eval_seg", 64'(seg_m), 64'd0);
        check("rst_eval_out_ready", 64'(eout_if.ready), 64'd0);
        check("rst_dbg_state", 64'(dbg_m), 64'd0);
        check("rst_one_in_ready", 64'(din1_if.ready), 64'd0);
        check("rst_one_seg", 64'(seg_1), 64'd0);

        rst = 1'b1;
        #1;
        check("idle_in_ready", 64'(din_if.ready), 64'd1);
        check("idle_one_in_ready", 64'(din1_if.ready), 64'd1);
        @(negedge clk);

        // Single lane: 1.0 in Q.12 -> segment 3, result valid at cycle 3
        din1_if.data[0] = 16'h1000;
        din1_if.valid   = 1'b1;
        ein1_if.ready   = 1'b1;
        check("one_in_ready", 64'(din1_if.ready), 64'd1);
        @(negedge clk);
        din1_if.valid = 1'b0;
        check("one_eval_valid", 64'(ein1_if.valid), 64'd1);
        check("one_eval_in", 64'(ein1_if.data[0]), 64'h1000);
        check("one_eval_seg", 64'(seg_1), 64'd3);
        @(negedge clk);
        check("one_eval_valid_done", 64'(ein1_if.valid), 64'd0);
        check("one_eval_out_ready", 64'(eout1_if.ready), 64'd1);
        check("one_out_valid_early", 64'(dout1_if.valid), 64'd0);
        eout1_if.valid   = 1'b1;
        eout1_if.data[0] = 32'h0001_2345;
        @(negedge clk);
        eout1_if.valid = 1'b0;
        check("one_out_valid", 64'(dout1_if.valid), 64'd1);
        check("one_out_data", 64'(dout1_if.data[0]), 64'h0001_2345);
        check("one_in_ready_done", 64'(din1_if.ready), 64'd0);
        dout1_if.ready = 1'b1;
        @(negedge clk);
        dout1_if.ready = 1'b0;
        check("one_out_valid_fall", 64'(dout1_if.valid), 64'd0);
        check("one_in_ready_again", 64'(din1_if.ready), 64'd1);

        // Basic 8-lane beat, 1-cycle evaluator: valid at N+2
        for (int k = 0; k < N; k++) lane_v[k] = W'(16'h1234 + k * 16'h0111);
        send_beat();
        expect_beat(N + 2, 0);

        // Segment edges
        for (int k = 0; k < N; k++) lane_v[k] = seg_lanes[k];
        send_beat();
        expect_beat(N + 2, 0);
        check("seg_count", 64'(seg_q.size()), 64'(N));
        for (int k = 0; k < N && seg_q.size() > 0; k++) begin
            check("seg_value", 64'(seg_q.pop_front()), 64'(seg_exp[k]));
        end

        // Ordering under 1..5 cycle evaluator latency
        lat_min = 1;
        lat_max = 5;
        for (int k = 0; k < N; k++) lane_v[k] = W'($urandom);
        send_beat();
        expect_beat(0, 0);

        // Evaluator input stalls plus 10-cycle downstream hold
        stall_en = 1'b1;
        lat_max  = 2;
        for (int k = 0; k < N; k++) lane_v[k] = W'($urandom);
        send_beat();
        expect_beat(0, 10);
        stall_en = 1'b0;

        // Asynchronous reset after two lanes collected
        lat_min = 1;
        lat_max = 3;
        for (int k = 0; k < N; k++) lane_v[k] = W'(16'hA000 + k);
        send_beat();
        w = 0;
        while (ev_out_cnt < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid_reached", 64'(ev_out_cnt >= 2), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(din_if.ready), 64'd0);
        check("mid_rst_out_valid", 64'(dout_if.valid), 64'd0);
        check("mid_rst_out_data", 64'(|dout_if.data), 64'd0);
        check("mid_rst_eval_valid", 64'(ein_if.valid), 64'd0);
        check("mid_rst_eval_in", 64'(ein_if.data[0]), 64'd0);
        check("mid_rst_eval_seg", 64'(seg_m), 64'd0);
        check("mid_rst_eval_out_ready", 64'(eout_if.ready), 64'd0);
        check("mid_rst_dbg_state", 64'(dbg_m), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(din_if.ready), 64'd1);
        check("post_rst_out_valid", 64'(dout_if.valid), 64'd0);

        // Three fresh back-to-back beats with a 1-cycle evaluator
        lat_min = 1;
        lat_max = 1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < N; k++) lane_v[k] = W'($urandom);
            send_beat();
            expect_beat(N + 2, 0);
        end

`ifdef SOFTPLUS_LANE_SEQ_PERF_EN
        check("perf_beats", 64'(perf_beats_m), 64'd3);
        check("perf_busy_cycles", 64'(perf_busy_m), 64'(3 * (N + 1)));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
